// File: rtl/fft_pkg.sv
// Shared types and sizing helpers for the FFT frame scheduler.
package fft_pkg;

  typedef enum logic [2:0] {
    ST_REST  = 3'd0,
    ST_WLOAD = 3'd1,
    ST_IDLE  = 3'd2,
    ST_FILL  = 3'd3,
    ST_ISSUE = 3'd4,
    ST_DRAIN = 3'd5
  } state_t;

  localparam int unsigned SAMPLE_W       = 16;
  localparam int unsigned NPOINT_DEFAULT = 3;

  function automatic int unsigned frame_len(input int unsigned npoint);
    return 32'd1 << npoint;
  endfunction

  function automatic int unsigned weight_num(input int unsigned npoint);
    return npoint * (frame_len(npoint) >> 1);
  endfunction

  localparam int unsigned FRAME_LEN  = frame_len(NPOINT_DEFAULT);
  localparam int unsigned WEIGHT_NUM = weight_num(NPOINT_DEFAULT);

endpackage

// File: rtl/fft_frame_unpacker.sv
// Parallel-load frame buffer emitted one sample per ready/valid beat, with last on the final slot.
module fft_frame_unpacker
  import fft_pkg::*;
#(
  parameter int unsigned NPOINT = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load,
  input  logic [(SAMPLE_W << NPOINT)-1:0]   frame_real,
  input  logic [(SAMPLE_W << NPOINT)-1:0]   frame_imag,
  output logic                              valid,
  input  logic                              ready,
  output logic [SAMPLE_W-1:0]               data_real,
  output logic [SAMPLE_W-1:0]               data_imag,
  output logic                              last,
  output logic                              done
);

  logic [(SAMPLE_W << NPOINT)-1:0] held_real;
  logic [(SAMPLE_W << NPOINT)-1:0] held_imag;
  logic [NPOINT-1:0]               slot;
  logic [NPOINT-1:0]               nxt;

  assign nxt  = slot + 1'b1;
  assign done = valid & ready & last;

  // Load a whole frame, then step through slots on each accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_real <= '0;
      held_imag <= '0;
      slot      <= '0;
      valid     <= 1'b0;
      last      <= 1'b0;
      data_real <= '0;
      data_imag <= '0;
    end else if (load) begin
      held_real <= frame_real;
      held_imag <= frame_imag;
      slot      <= '0;
      valid     <= 1'b1;
      last      <= 1'b0;
      data_real <= frame_real[SAMPLE_W-1:0];
      data_imag <= frame_imag[SAMPLE_W-1:0];
    end else if (valid && ready) begin
      if (last) begin
        valid <= 1'b0;
        last  <= 1'b0;
      end else begin
        slot      <= nxt;
        data_real <= held_real[SAMPLE_W*nxt +: SAMPLE_W];
        data_imag <= held_imag[SAMPLE_W*nxt +: SAMPLE_W];
        last      <= (nxt == '1);
      end
    end
  end

endmodule

// File: rtl/fft_frame_scheduler.sv
// Sequences the parallel FFT core: weight load, serial->frame packing, issue, and result drain.
module fft_frame_scheduler
  import fft_pkg::*;
#(
  parameter int unsigned NPOINT = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              w_in_valid,
  output logic                              w_in_ready,
  input  logic [15:0]                       w_in_real,
  input  logic [15:0]                       w_in_imag,
  input  logic                              reload_weights,
  input  logic                              s_in_valid,
  output logic                              s_in_ready,
  input  logic [15:0]                       s_in_real,
  input  logic [15:0]                       s_in_imag,
  output logic                              s_out_valid,
  input  logic                              s_out_ready,
  output logic [15:0]                       s_out_real,
  output logic [15:0]                       s_out_imag,
  output logic                              s_out_last,
  output logic                              fft_weight_valid,
  output logic [15:0]                       fft_weight_real,
  output logic [15:0]                       fft_weight_imag,
  output logic                              fft_din_valid,
  input  logic                              fft_din_busy,
  output logic [(SAMPLE_W << NPOINT)-1:0]   fft_din_real,
  output logic [(SAMPLE_W << NPOINT)-1:0]   fft_din_imag,
  input  logic                              fft_dout_valid,
  output logic                              fft_dout_busy,
  input  logic [(SAMPLE_W << NPOINT)-1:0]   fft_dout_real,
  input  logic [(SAMPLE_W << NPOINT)-1:0]   fft_dout_imag,
  output logic                              weights_loaded
);

  localparam int unsigned       WCW    = 2 * NPOINT;
  localparam logic [WCW-1:0]    W_LAST = WCW'(weight_num(NPOINT) - 1);
  localparam logic [NPOINT-1:0] S_LAST = '1;

  state_t            state;
  logic [WCW-1:0]    wcnt;
  logic [NPOINT-1:0] scnt;
  logic              unpack_load;
  logic              drain_done;

  // Result capture happens the same edge the FSM leaves IDLE for DRAIN.
  assign unpack_load = (state == ST_IDLE) && fft_dout_valid;

  // Control FSM with registered handshakes, weight path and frame packer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_REST;
      wcnt             <= '0;
      scnt             <= '0;
      w_in_ready       <= 1'b0;
      s_in_ready       <= 1'b0;
      fft_weight_valid <= 1'b0;
      fft_weight_real  <= '0;
      fft_weight_imag  <= '0;
      fft_din_valid    <= 1'b0;
      fft_din_real     <= '0;
      fft_din_imag     <= '0;
      fft_dout_busy    <= 1'b1;
      weights_loaded   <= 1'b0;
    end else begin
      fft_weight_valid <= 1'b0;
      case (state)
        ST_REST: begin
          wcnt       <= '0;
          w_in_ready <= 1'b1;
          state      <= ST_WLOAD;
        end
        ST_WLOAD: begin
          if (w_in_valid && w_in_ready) begin
            fft_weight_valid <= 1'b1;
            fft_weight_real  <= w_in_real;
            fft_weight_imag  <= w_in_imag;
            if (wcnt == W_LAST) begin
              wcnt           <= '0;
              weights_loaded <= 1'b1;
              w_in_ready     <= 1'b0;
              fft_dout_busy  <= 1'b0;
              state          <= ST_IDLE;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        ST_IDLE: begin
          if (fft_dout_valid) begin
            fft_dout_busy <= 1'b1;
            state         <= ST_DRAIN;
          end else if (reload_weights) begin
            weights_loaded <= 1'b0;
            w_in_ready     <= 1'b1;
            fft_dout_busy  <= 1'b1;
            state          <= ST_WLOAD;
          end else if (s_in_valid) begin
            s_in_ready    <= 1'b1;
            fft_dout_busy <= 1'b1;
            state         <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (s_in_valid && s_in_ready) begin
            fft_din_real[SAMPLE_W*scnt +: SAMPLE_W] <= s_in_real;
            fft_din_imag[SAMPLE_W*scnt +: SAMPLE_W] <= s_in_imag;
            if (scnt == S_LAST) begin
              scnt          <= '0;
              s_in_ready    <= 1'b0;
              fft_din_valid <= 1'b1;
              state         <= ST_ISSUE;
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (!fft_din_busy) begin
            fft_din_valid <= 1'b0;
            fft_dout_busy <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            fft_dout_busy <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: begin
          w_in_ready     <= 1'b0;
          s_in_ready     <= 1'b0;
          fft_din_valid  <= 1'b0;
          fft_dout_busy  <= 1'b1;
          weights_loaded <= 1'b0;
          state          <= ST_REST;
        end
      endcase
    end
  end

  fft_frame_unpacker #(.NPOINT(NPOINT)) u_unpacker (
    .clk        (clk),
    .rst        (rst),
    .load       (unpack_load),
    .frame_real (fft_dout_real),
    .frame_imag (fft_dout_imag),
    .valid      (s_out_valid),
    .ready      (s_out_ready),
    .data_real  (s_out_real),
    .data_imag  (s_out_imag),
    .last       (s_out_last),
    .done       (drain_done)
  );

endmodule
